// File: rtl/sensor_debounce.sv
// Two-channel sensor conditioner: 2-FF synchroniser, then a debounce FSM per channel.
// Channel 0 is sensor a and channel 1 is sensor b. Each channel drives a clean level
// and 1-cycle rise/fall ticks, all registered.
module sensor_debounce #(
    parameter int unsigned N = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic a_db,
    output logic b_db,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    typedef enum logic [1:0] {StZero, StWait1, StOne, StWait0} state_e;

    localparam logic [N-1:0] CntMax = '1;
    localparam logic [N-1:0] CntOne = N'(1);

    logic [1:0] raw;
    logic [1:0] db;
    logic [1:0] rise;
    logic [1:0] fall;

    assign raw = {b, a};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic         s1_q, s2_q;
        state_e       state_q, state_d;
        logic [N-1:0] cnt_q, cnt_d;
        logic         db_q, db_d;
        logic         rise_q, rise_d;
        logic         fall_q, fall_d;

        // Two-stage synchroniser; the FSM only ever looks at s2_q.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= raw[ch];
                s2_q <= s1_q;
            end
        end

        // State, counter and registered outputs.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= StZero;
                cnt_q   <= '0;
                db_q    <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                db_q    <= db_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // Next state: a new level must persist through a full countdown before it commits.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            db_d    = db_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            unique case (state_q)
                StZero: begin
                    if (s2_q) begin
                        state_d = StWait1;
                        cnt_d   = CntMax;
                    end
                end
                StWait1: begin
                    if (!s2_q) begin
                        state_d = StZero;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntOne;
                    end else begin
                        state_d = StOne;
                        db_d    = 1'b1;
                        rise_d  = 1'b1;
                    end
                end
                StOne: begin
                    if (!s2_q) begin
                        state_d = StWait0;
                        cnt_d   = CntMax;
                    end
                end
                StWait0: begin
                    if (s2_q) begin
                        state_d = StOne;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntOne;
                    end else begin
                        state_d = StZero;
                        db_d    = 1'b0;
                        fall_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = StZero;
                end
            endcase
        end

        assign db[ch]   = db_q;
        assign rise[ch] = rise_q;
        assign fall[ch] = fall_q;
    end

    assign a_db   = db[0];
    assign b_db   = db[1];
    assign a_rise = rise[0];
    assign a_fall = fall[0];
    assign b_rise = rise[1];
    assign b_fall = fall[1];

endmodule

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce with N=3: directed scenarios plus randomized bouncing inputs,
// checked every cycle against a run-length reference model.
module tb_sensor_debounce;

    localparam int unsigned N   = 3;
    localparam int          Win = (1 << N) + 1;  // consecutive synced cycles needed to commit

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a = 1'b0;
    logic b = 1'b0;
    logic a_db, b_db, a_rise, a_fall, b_rise, b_fall;

    sensor_debounce #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .a_db   (a_db),
        .b_db   (b_db),
        .a_rise (a_rise),
        .a_fall (a_fall),
        .b_rise (b_rise),
        .b_fall (b_fall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state per channel (0 = a, 1 = b).
    logic m_s1[2];
    logic m_s2[2];
    logic m_db[2];
    logic m_rise[2];
    logic m_fall[2];
    int   m_run[2];

    // Event statistics for the directed scenarios.
    int edge_no;
    int n_rise[2];
    int n_fall[2];
    int rise_at[2];
    int fall_at[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_s1[ch] = 1'b0;
            m_s2[ch] = 1'b0;
            m_db[ch] = 1'b0;
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            m_run[ch] = 0;
        end
    endtask

    // One clock edge: the level seen two edges ago must differ from db for Win
    // consecutive edges before db follows it.
    task automatic model_edge(input logic ra, input logic rb);
        logic raw[2];
        raw[0] = ra;
        raw[1] = rb;
        for (int ch = 0; ch < 2; ch++) begin
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            if (m_s2[ch] != m_db[ch]) begin
                m_run[ch]++;
                if (m_run[ch] == Win) begin
                    m_db[ch]   = ~m_db[ch];
                    m_rise[ch] = m_db[ch];
                    m_fall[ch] = ~m_db[ch];
                    m_run[ch]  = 0;
                end
            end else begin
                m_run[ch] = 0;
            end
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = raw[ch];
        end
    endtask

    task automatic compare_all();
        check("a_db",   a_db,   m_db[0]);
        check("a_rise", a_rise, m_rise[0]);
        check("a_fall", a_fall, m_fall[0]);
        check("b_db",   b_db,   m_db[1]);
        check("b_rise", b_rise, m_rise[1]);
        check("b_fall", b_fall, m_fall[1]);
    endtask

    task automatic clear_stats();
        edge_no = 0;
        for (int ch = 0; ch < 2; ch++) begin
            n_rise[ch] = 0;
            n_fall[ch] = 0;
            rise_at[ch] = -1;
            fall_at[ch] = -1;
        end
    endtask

    // Called at a negedge; drives inputs, takes one posedge, checks, returns at the next negedge.
    task automatic step(input logic va, input logic vb);
        logic r[2];
        logic f[2];
        a = va;
        b = vb;
        @(posedge clk);
        if (!reset) model_edge(va, vb);
        #1;
        compare_all();
        edge_no++;
        r[0] = a_rise; r[1] = b_rise;
        f[0] = a_fall; f[1] = b_fall;
        for (int ch = 0; ch < 2; ch++) begin
            if (r[ch] === 1'b1) begin
                n_rise[ch]++;
                if (rise_at[ch] < 0) rise_at[ch] = edge_no;
            end
            if (f[ch] === 1'b1) begin
                n_fall[ch]++;
                if (fall_at[ch] < 0) fall_at[ch] = edge_no;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting at the current negedge, keeping the present inputs.
    task automatic pulse_reset(input int cycles);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        for (int i = 0; i < cycles; i++) step(a, b);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_stats();

        // 1: outputs held low during reset with a=b=1, then a rises after 11 edges.
        a = 1'b1;
        b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
        clear_stats();
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
        check("t1_rise_edge", rise_at[0], 11);
        check("t1_rise_count", n_rise[0], 1);

        // 2: a 4-cycle pulse is rejected.
        pulse_reset(2);
        clear_stats();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0);
        check("t2_no_rise", n_rise[0], 0);
        check("t2_db_low", a_db, 1'b0);

        // 3: bounce while high, then settle low; one fall 11 edges after the last change.
        pulse_reset(2);
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0);
        clear_stats();
        for (int i = 0; i < 6; i++) step(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0);
        check("t3_fall_count", n_fall[0], 1);
        check("t3_fall_edge", fall_at[0], 16);

        // 4: simultaneous rise on both channels.
        pulse_reset(2);
        clear_stats();
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
        check("t4_a_rise_edge", rise_at[0], 11);
        check("t4_b_rise_edge", rise_at[1], 11);
        check("t4_a_rise_count", n_rise[0], 1);
        check("t4_b_rise_count", n_rise[1], 1);

        // 5: reset in the middle of the window discards it; restart after release.
        pulse_reset(2);
        clear_stats();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        pulse_reset(2);
        check("t5_no_rise", n_rise[0], 0);
        clear_stats();
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
        check("t5_rise_edge", rise_at[0], 11);

        // 6: long steady high: single rise, no spurious activity afterwards.
        pulse_reset(2);
        clear_stats();
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b0);
        check("t6_rise_count", n_rise[0], 1);
        check("t6_fall_count", n_fall[0], 0);
        check("t6_db_high", a_db, 1'b1);

        // Random: each channel holds a random level for a random time, with rare resets.
        begin
            logic va, vb;
            int   ha, hb;
            va = 1'b0; vb = 1'b0; ha = 0; hb = 0;
            for (int i = 0; i < 1500; i++) begin
                if (ha == 0) begin
                    va = 1'($urandom_range(1));
                    ha = $urandom_range(14, 1);
                end
                if (hb == 0) begin
                    vb = 1'($urandom_range(1));
                    hb = $urandom_range(14, 1);
                end
                ha--;
                hb--;
                if ($urandom_range(199) == 0) begin
                    a = va;
                    b = vb;
                    pulse_reset($urandom_range(3, 1));
                end else begin
                    step(va, vb);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
